// File: rtl/multicycle_alu_pkg.sv
// alu_pkg: opcode encodings, FSM states and the registered result record
// shared by multicycle_alu and its testbench.
package alu_pkg;

   localparam logic [5:0] OP_ADDU  = 6'b001001;
   localparam logic [5:0] OP_SUBU  = 6'b001010;
   localparam logic [5:0] OP_MULTU = 6'b011001;
   localparam logic [5:0] OP_DIVU  = 6'b011011;

   // Result fields are sized for the widest supported build; tops use the low WIDTH bits.
   localparam int ALU_MAX_W = 64;

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} alu_state_e;

   typedef struct packed {
      logic [ALU_MAX_W-1:0] hi;
      logic [ALU_MAX_W-1:0] lo;
      logic                 carry;
      logic                 illegal;
   } alu_res_t;

endpackage

// File: rtl/multicycle_alu_if.sv
// Request/response bundle for multicycle_alu: valid/ready on both sides.
interface multicycle_alu_if #(parameter int WIDTH = 32);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] Src_1;
   logic [WIDTH-1:0] Src_2;
   logic [5:0]       OP_ctrl;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] ALU_Result;
   logic [WIDTH-1:0] ALU_Result_Hi;
   logic             ALU_Carry;
   logic             ALU_Illegal;

   modport master (
      output in_valid, Src_1, Src_2, OP_ctrl, out_ready,
      input  in_ready, out_valid, ALU_Result, ALU_Result_Hi, ALU_Carry, ALU_Illegal
   );

   modport slave (
      input  in_valid, Src_1, Src_2, OP_ctrl, out_ready,
      output in_ready, out_valid, ALU_Result, ALU_Result_Hi, ALU_Carry, ALU_Illegal
   );

endinterface

// File: rtl/multicycle_alu_iter_unit.sv
// alu_iter_unit: one-bit-per-cycle shift-add multiplier, plus restoring divider
// when MULTICYCLE_ALU_DIVU_EN is defined. hi_nxt/lo_nxt show the state after the current step.
module alu_iter_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             mode,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi_nxt,
   output logic [WIDTH-1:0] lo_nxt
);

   logic [WIDTH-1:0] hi_q, lo_q, b_q;
   logic [WIDTH:0]   sum;

`ifdef MULTICYCLE_ALU_DIVU_EN
   logic             mode_q;
   logic [WIDTH:0]   trial;
`else
   logic             unused_mode;
   assign unused_mode = mode;
`endif

   always_comb begin
      // Multiply: {hi,lo} holds partial product with the multiplier draining out of lo.
      sum = {1'b0, hi_q} + {1'b0, b_q};
      if (lo_q[0]) {hi_nxt, lo_nxt} = {sum, lo_q[WIDTH-1:1]};
      else         {hi_nxt, lo_nxt} = {1'b0, hi_q, lo_q[WIDTH-1:1]};
`ifdef MULTICYCLE_ALU_DIVU_EN
      // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
      // A zero divisor always "fits", yielding all-ones quotient and remainder = dividend.
      trial = {hi_q, lo_q[WIDTH-1]};
      if (mode_q) begin
         if (trial >= {1'b0, b_q}) begin
            hi_nxt = trial[WIDTH-1:0] - b_q;
            lo_nxt = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            hi_nxt = trial[WIDTH-1:0];
            lo_nxt = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         b_q  <= '0;
`ifdef MULTICYCLE_ALU_DIVU_EN
         mode_q <= 1'b0;
`endif
      end else if (start) begin
         hi_q <= '0;
         lo_q <= a;
         b_q  <= b;
`ifdef MULTICYCLE_ALU_DIVU_EN
         mode_q <= mode;
`endif
      end else if (step) begin
         hi_q <= hi_nxt;
         lo_q <= lo_nxt;
      end
   end

endmodule

// File: rtl/multicycle_alu.sv
// multicycle_alu: unsigned addu/subu/multu (and divu with MULTICYCLE_ALU_DIVU_EN),
// one op in flight, valid/ready on both sides, registered results.
module multicycle_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   multicycle_alu_if.slave    bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   alu_state_e       state_q, state_n;
   alu_res_t         res_q, res_n;
   logic [CNT_W-1:0] cnt_q;
   logic             accept, cnt_done, is_iter, is_div, div_q, bz_q;
   logic [WIDTH:0]   addsub;
   logic [WIDTH-1:0] it_hi, it_lo;
   logic             unused_res;

   always_comb begin
      state_n  = state_q;
      res_n    = res_q;
      accept   = bus.in_valid && (state_q == S_IDLE);
      cnt_done = (cnt_q == '0);
      is_iter  = (bus.OP_ctrl == OP_MULTU);
      is_div   = 1'b0;
`ifdef MULTICYCLE_ALU_DIVU_EN
      if (bus.OP_ctrl == OP_DIVU) begin
         is_iter = 1'b1;
         is_div  = 1'b1;
      end
`endif
      // Bit WIDTH is carry for addu and borrow for subu.
      if (bus.OP_ctrl == OP_SUBU) addsub = {1'b0, bus.Src_1} - {1'b0, bus.Src_2};
      else                        addsub = {1'b0, bus.Src_1} + {1'b0, bus.Src_2};

      case (state_q)
         S_IDLE: if (accept) begin
            if (is_iter) state_n = S_BUSY;
            else begin
               state_n = S_DONE;
               res_n   = '0;
               if (bus.OP_ctrl == OP_ADDU || bus.OP_ctrl == OP_SUBU) begin
                  res_n.lo    = ALU_MAX_W'(addsub[WIDTH-1:0]);
                  res_n.carry = addsub[WIDTH];
               end else res_n.illegal = 1'b1;
            end
         end
         S_BUSY: if (cnt_done) begin
            state_n     = S_DONE;
            res_n       = '0;
            res_n.hi    = ALU_MAX_W'(it_hi);
            res_n.lo    = ALU_MAX_W'(it_lo);
            res_n.carry = div_q & bz_q;
         end
         S_DONE: if (bus.out_ready) state_n = S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         res_q   <= '0;
         cnt_q   <= '0;
         div_q   <= 1'b0;
         bz_q    <= 1'b0;
      end else begin
         state_q <= state_n;
         res_q   <= res_n;
         if (accept) begin
            cnt_q <= CNT_W'(WIDTH - 1);
            div_q <= is_div;
            bz_q  <= (bus.Src_2 == '0);
         end else if (state_q == S_BUSY && !cnt_done) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end
      end
   end

   alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rst    (rst),
      .start  (accept && is_iter),
      .mode   (is_div),
      .step   (state_q == S_BUSY),
      .a      (bus.Src_1),
      .b      (bus.Src_2),
      .hi_nxt (it_hi),
      .lo_nxt (it_lo)
   );

   assign bus.in_ready      = (state_q == S_IDLE);
   assign bus.out_valid     = (state_q == S_DONE);
   assign bus.ALU_Result    = res_q.lo[WIDTH-1:0];
   assign bus.ALU_Result_Hi = res_q.hi[WIDTH-1:0];
   assign bus.ALU_Carry     = res_q.carry;
   assign bus.ALU_Illegal   = res_q.illegal;
   assign unused_res        = ^{res_q.hi, res_q.lo};

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed bench for multicycle_alu: 32-bit vector table, multi-cycle corner sequences,
// and an 8-bit instance. divu expectations follow MULTICYCLE_ALU_DIVU_EN.
module tb_multicycle_alu;
   import alu_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   n_err = 0;
   int   n_chk = 0;

   always #5 clk = ~clk;

   multicycle_alu_if #(.WIDTH(32)) bus ();
   multicycle_alu_if #(.WIDTH(8))  bus8 ();

   multicycle_alu #(.WIDTH(32)) dut   (.clk(clk), .rst(rst), .bus(bus));
   multicycle_alu #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

   typedef struct {
      logic [5:0]  op;
      logic [31:0] a, b, lo, hi;
      logic        c, ill;
      int          lat;
   } vec_t;

   vec_t vt[$];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Present one request, wait (bounded) for out_valid; lat counts cycles after the accept cycle.
   task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
      bus.OP_ctrl = op; bus.Src_1 = a; bus.Src_2 = b; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin tick(); lat++; end
   endtask

   task automatic run_op8(input logic [5:0] op, input logic [7:0] a, input logic [7:0] b,
                          output int lat);
      bus8.OP_ctrl = op; bus8.Src_1 = a; bus8.Src_2 = b; bus8.in_valid = 1'b1;
      tick();
      bus8.in_valid = 1'b0;
      lat = 1;
      while (!bus8.out_valid && lat < 100) begin tick(); lat++; end
   endtask

   task automatic handshake();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      int lat, bad;
      logic [31:0] r_lo, r_hi;

      rst = 1'b1;
      bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.OP_ctrl = '0; bus.Src_1 = '0; bus.Src_2 = '0;
      bus8.in_valid = 1'b0; bus8.out_ready = 1'b0; bus8.OP_ctrl = '0; bus8.Src_1 = '0; bus8.Src_2 = '0;

      vt.push_back('{OP_ADDU,  32'hFFFF_FFFF, 32'h1,        32'h0,        32'h0,  1'b1, 1'b0, 1});
      vt.push_back('{OP_SUBU,  32'd5,         32'd7,        32'hFFFF_FFFE, 32'h0, 1'b1, 1'b0, 1});
      vt.push_back('{OP_ADDU,  32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 32'h0, 1'b0, 1'b0, 1});
      vt.push_back('{OP_SUBU,  32'd10,        32'd3,        32'd7,        32'h0,  1'b0, 1'b0, 1});
      vt.push_back('{OP_SUBU,  32'd7,         32'd7,        32'd0,        32'h0,  1'b0, 1'b0, 1});
      vt.push_back('{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 33});
      vt.push_back('{OP_MULTU, 32'd3,         32'd5,        32'd15,       32'h0,  1'b0, 1'b0, 33});
      vt.push_back('{OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0,       32'h1,  1'b0, 1'b0, 33});
      vt.push_back('{OP_MULTU, 32'h1234_5678, 32'h100,      32'h3456_7800, 32'h12, 1'b0, 1'b0, 33});
      vt.push_back('{6'b000000, 32'd9,        32'd4,        32'h0,        32'h0,  1'b0, 1'b1, 1});
      vt.push_back('{6'b111111, 32'd9,        32'd4,        32'h0,        32'h0,  1'b0, 1'b1, 1});
`ifdef MULTICYCLE_ALU_DIVU_EN
      vt.push_back('{OP_DIVU,  32'd100,       32'd7,        32'd14,       32'd2,  1'b0, 1'b0, 33});
      vt.push_back('{OP_DIVU,  32'd9,         32'd0,        32'hFFFF_FFFF, 32'd9, 1'b1, 1'b0, 33});
      vt.push_back('{OP_DIVU,  32'hFFFF_FFFF, 32'h10,       32'h0FFF_FFFF, 32'hF, 1'b0, 1'b0, 33});
`else
      vt.push_back('{OP_DIVU,  32'd100,       32'd7,        32'h0,        32'h0,  1'b0, 1'b1, 1});
      vt.push_back('{OP_DIVU,  32'd9,         32'd0,        32'h0,        32'h0,  1'b0, 1'b1, 1});
`endif

      tick(); tick();
      rst = 1'b0;
      tick();
      chk("reset out_valid", bus.out_valid, 0);
      chk("reset in_ready",  bus.in_ready, 1);
      chk("reset result",    {bus.ALU_Result_Hi, bus.ALU_Result}, 0);
      chk("reset flags",     {bus.ALU_Carry, bus.ALU_Illegal}, 0);

      foreach (vt[i]) begin
         run_op(vt[i].op, vt[i].a, vt[i].b, lat);
         chk($sformatf("v%0d latency", i), lat, vt[i].lat);
         chk($sformatf("v%0d lo", i), bus.ALU_Result, vt[i].lo);
         chk($sformatf("v%0d hi", i), bus.ALU_Result_Hi, vt[i].hi);
         chk($sformatf("v%0d carry", i), bus.ALU_Carry, vt[i].c);
         chk($sformatf("v%0d illegal", i), bus.ALU_Illegal, vt[i].ill);
         handshake();
         chk($sformatf("v%0d post out_valid", i), bus.out_valid, 0);
         chk($sformatf("v%0d post in_ready", i), bus.in_ready, 1);
      end

      // multu with inputs churning while busy: no accept, result from the latched operands.
      bus.OP_ctrl = OP_MULTU; bus.Src_1 = 32'hFFFF_FFFF; bus.Src_2 = 32'hFFFF_FFFF; bus.in_valid = 1'b1;
      tick();
      lat = 1; bad = 0;
      while (!bus.out_valid && lat < 100) begin
         if (bus.in_ready) bad++;
         bus.in_valid = 1'($urandom_range(0, 1));
         bus.Src_1 = $urandom; bus.Src_2 = $urandom; bus.OP_ctrl = OP_ADDU;
         tick(); lat++;
      end
      bus.in_valid = 1'b0;
      chk("toggle latency", lat, 33);
      chk("toggle busy in_ready", bad, 0);
      chk("toggle hi", bus.ALU_Result_Hi, 32'hFFFF_FFFE);
      chk("toggle lo", bus.ALU_Result, 32'h0000_0001);
      handshake();

      // Backpressure: results hold and requests are refused while out_ready is low.
      run_op(OP_ADDU, 32'd3, 32'd4, lat);
      chk("bp latency", lat, 1);
      bad = 0;
      for (int k = 0; k < 5; k++) begin
         bus.in_valid = 1'b1; bus.OP_ctrl = OP_SUBU; bus.Src_1 = $urandom; bus.Src_2 = $urandom;
         tick();
         if (!bus.out_valid || bus.in_ready || bus.ALU_Result != 32'd7 || bus.ALU_Carry) bad++;
      end
      chk("bp stall stable", bad, 0);
      bus.in_valid = 1'b0;
      handshake();
      chk("bp released out_valid", bus.out_valid, 0);
      chk("bp released in_ready", bus.in_ready, 1);
      chk("bp held result", bus.ALU_Result, 32'd7);

      // Reset held two cycles mid-multu abandons the op.
      bus.OP_ctrl = OP_MULTU; bus.Src_1 = 32'd1000; bus.Src_2 = 32'd1000; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      chk("midrst out_valid", bus.out_valid, 0);
      chk("midrst result", {bus.ALU_Result_Hi, bus.ALU_Result}, 0);
      tick();
      chk("midrst in_ready", bus.in_ready, 1);
      bad = 0;
      repeat (40) begin
         if (bus.out_valid) bad++;
         tick();
      end
      chk("midrst no stale out_valid", bad, 0);

      // 8-bit build.
      run_op8(OP_MULTU, 8'hFF, 8'hFF, lat);
      chk("w8 mul latency", lat, 9);
      chk("w8 mul hi", bus8.ALU_Result_Hi, 8'hFE);
      chk("w8 mul lo", bus8.ALU_Result, 8'h01);
      bus8.out_ready = 1'b1; tick(); bus8.out_ready = 1'b0;
      run_op8(6'b000000, 8'h12, 8'h34, lat);
      chk("w8 illegal latency", lat, 1);
      chk("w8 illegal flag", bus8.ALU_Illegal, 1);
      chk("w8 illegal result", {bus8.ALU_Result_Hi, bus8.ALU_Result}, 0);
      bus8.out_ready = 1'b1; tick(); bus8.out_ready = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
